// File: rtl/cpu_mem_pkg.sv
// cpu_mem_pkg -- shared constants and types for the CPU memory responder.
//   MEM_ADDR_W / MEM_DATA_W / MEM_DEPTH : default memory geometry
//   ld_state_t                          : program-loader FSM states
//   zero16 / zero8                      : common zero constants
package cpu_mem_pkg;

    localparam int MEM_ADDR_W = 8;
    localparam int MEM_DATA_W = 16;
    localparam int MEM_DEPTH  = 256;

    localparam logic [15:0] zero16 = 16'h0000;
    localparam logic [7:0]  zero8  = 8'h00;

    typedef enum logic [1:0] {
        LD_IDLE = 2'd0,
        LD_LOAD = 2'd1,
        LD_DONE = 2'd2
    } ld_state_t;

endpackage

// File: rtl/cpu_mem_mem_bank.sv
// mem_bank -- DEPTH x DATA_W word array.
//   clock          : write clock
//   we/waddr/wdata : synchronous write port (takes effect on the rising edge)
//   raddr/rdata    : combinational read port (old word during a same-cycle write)
// No reset: contents survive loader/CPU resets by design.
module mem_bank #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 16,
    parameter int DEPTH  = 256
) (
    input  logic              clock,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clock) begin
        if (we) mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/cpu_mem.sv
// cpu_mem -- instruction + data memory responder for the pipelined CPU,
// with a host program-loader FSM (valid/ready) that fills either memory.
//   clock, reset (async, active-low; loader state only)
//   i_addr -> i_datain         : instruction fetch, combinational, zero in LOAD
//   d_addr -> d_datain         : data load, combinational
//   d_dataout, d_we            : CPU store, ignored while loading
//   ld_start, ld_sel           : start session, target (0 imem, 1 dmem)
//   ld_valid, ld_data, ld_last : host word stream
//   ld_ready, ld_busy, ld_done : loader status (registered)
//   ld_count                   : words written this / last session
module cpu_mem
    import cpu_mem_pkg::*;
#(
    parameter int ADDR_W = MEM_ADDR_W,
    parameter int DATA_W = MEM_DATA_W,
    parameter int DEPTH  = MEM_DEPTH
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [ADDR_W-1:0] i_addr,
    output logic [DATA_W-1:0] i_datain,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_dataout,
    input  logic              d_we,
    output logic [DATA_W-1:0] d_datain,
    input  logic              ld_start,
    input  logic              ld_sel,
    input  logic              ld_valid,
    input  logic [DATA_W-1:0] ld_data,
    input  logic              ld_last,
    output logic              ld_ready,
    output logic              ld_busy,
    output logic              ld_done,
    output logic [ADDR_W:0]   ld_count
);

    typedef struct packed {
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } wr_req_t;

    ld_state_t         state;
    logic              sel;
    logic [ADDR_W-1:0] ptr;
    logic              accept;
    logic              in_load;
    wr_req_t           iw, dw;
    logic [DATA_W-1:0] imem_rd;

    assign in_load = (state == LD_LOAD);
    assign accept  = ld_ready & ld_valid;

    // Loader FSM; all status outputs registered alongside the state.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state    <= LD_IDLE;
            sel      <= 1'b0;
            ptr      <= '0;
            ld_count <= '0;
            ld_ready <= 1'b0;
            ld_busy  <= 1'b0;
            ld_done  <= 1'b0;
        end else begin
            case (state)
                LD_IDLE: begin
                    ld_done <= 1'b0;
                    if (ld_start) begin
                        state    <= LD_LOAD;
                        sel      <= ld_sel;
                        ptr      <= '0;
                        ld_count <= '0;
                        ld_ready <= 1'b1;
                        ld_busy  <= 1'b1;
                    end
                end
                LD_LOAD: begin
                    if (accept) begin
                        ptr      <= ptr + 1'b1;
                        ld_count <= ld_count + 1'b1;
                        // Top address written: end here so the pointer never
                        // wraps back onto word 0.
                        if (ld_last || (&ptr)) begin
                            state    <= LD_DONE;
                            ld_ready <= 1'b0;
                            ld_busy  <= 1'b0;
                            ld_done  <= 1'b1;
                        end
                    end
                end
                LD_DONE: begin
                    state   <= LD_IDLE;
                    ld_done <= 1'b0;
                end
                default: begin
                    state    <= LD_IDLE;
                    ld_ready <= 1'b0;
                    ld_busy  <= 1'b0;
                    ld_done  <= 1'b0;
                end
            endcase
        end
    end

    // Write steering: loader owns both ports in LOAD, CPU store otherwise.
    always_comb begin
        iw = '0;
        dw = '0;
        if (accept) begin
            if (sel) begin
                dw.we   = 1'b1;
                dw.addr = ptr;
                dw.data = ld_data;
            end else begin
                iw.we   = 1'b1;
                iw.addr = ptr;
                iw.data = ld_data;
            end
        end else if (d_we && !in_load) begin
            dw.we   = 1'b1;
            dw.addr = d_addr;
            dw.data = d_dataout;
        end
    end

    mem_bank #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH)) imem (
        .clock (clock),
        .we    (iw.we),
        .waddr (iw.addr),
        .wdata (iw.data),
        .raddr (i_addr),
        .rdata (imem_rd)
    );

    mem_bank #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH)) dmem (
        .clock (clock),
        .we    (dw.we),
        .waddr (dw.addr),
        .wdata (dw.data),
        .raddr (d_addr),
        .rdata (d_datain)
    );

    // CPU fetches NOPs while its program is being replaced.
    assign i_datain = in_load ? '0 : imem_rd;

endmodule

// File: tb/tb_cpu_mem.sv
module tb_cpu_mem;

    logic        clock = 1'b0;
    logic        reset;
    logic [7:0]  i_addr;
    logic [15:0] i_datain;
    logic [7:0]  d_addr;
    logic [15:0] d_dataout;
    logic        d_we;
    logic [15:0] d_datain;
    logic        ld_start, ld_sel, ld_valid, ld_last;
    logic [15:0] ld_data;
    logic        ld_ready, ld_busy, ld_done;
    logic [8:0]  ld_count;

    always #5 clock = ~clock;

    cpu_mem dut (
        .clock(clock), .reset(reset),
        .i_addr(i_addr), .i_datain(i_datain),
        .d_addr(d_addr), .d_dataout(d_dataout), .d_we(d_we), .d_datain(d_datain),
        .ld_start(ld_start), .ld_sel(ld_sel), .ld_valid(ld_valid),
        .ld_data(ld_data), .ld_last(ld_last),
        .ld_ready(ld_ready), .ld_busy(ld_busy), .ld_done(ld_done),
        .ld_count(ld_count)
    );

    // Reference model: known contents of each memory.
    logic [15:0] im [256];
    logic [15:0] dm [256];
    bit          im_v [256];
    bit          dm_v [256];
    logic [15:0] words [$];

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic readback();
        for (int a = 0; a < 256; a++) begin
            i_addr = 8'(a);
            d_addr = 8'(a);
            #1;
            if (im_v[a]) chk($sformatf("imem[%0d]", a), {16'h0, i_datain}, {16'h0, im[a]});
            if (dm_v[a]) chk($sformatf("dmem[%0d]", a), {16'h0, d_datain}, {16'h0, dm[a]});
        end
    endtask

    // One loader session over the words queue. Without ld_last the session
    // must end by itself after 256 words. Random CPU stores, fetch addresses
    // and stray ld_start pulses are thrown in to show they are ignored.
    task automatic run_load(input bit sel, input bit use_last, input bit gaps);
        int idx = 0;
        int cyc = 0;
        int exp_n;
        bit v;
        exp_n = use_last ? words.size() : 256;
        ld_start = 1'b1;
        ld_sel   = sel;
        tick();
        ld_start = 1'b0;
        chk("busy_on", {31'h0, ld_busy}, 32'd1);
        chk("ready_on", {31'h0, ld_ready}, 32'd1);
        chk("count_clr", {23'h0, ld_count}, 32'd0);
        while (idx < exp_n && cyc < 2000) begin
            v         = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
            ld_valid  = v;
            ld_data   = words[idx];
            ld_last   = use_last && (idx == words.size() - 1);
            ld_start  = 1'(gaps ? $urandom_range(0, 1) : 0);
            ld_sel    = ~sel;
            i_addr    = 8'($urandom);
            d_addr    = 8'($urandom);
            d_dataout = 16'($urandom);
            d_we      = 1'($urandom);
            #1;
            chk("busy_in_load", {31'h0, ld_busy}, 32'd1);
            chk("i_nop_in_load", {16'h0, i_datain}, 32'd0);
            if (dm_v[d_addr]) chk("d_read_in_load", {16'h0, d_datain}, {16'h0, dm[d_addr]});
            tick();
            if (v) begin
                if (sel) begin dm[idx] = words[idx]; dm_v[idx] = 1'b1; end
                else     begin im[idx] = words[idx]; im_v[idx] = 1'b1; end
                idx++;
            end
            cyc++;
        end
        chk("sess_len", idx, exp_n);
        ld_valid = 1'b0; ld_last = 1'b0; ld_start = 1'b0; d_we = 1'b0;
        #1;
        chk("done_pulse", {31'h0, ld_done}, 32'd1);
        chk("busy_off", {31'h0, ld_busy}, 32'd0);
        chk("ready_off", {31'h0, ld_ready}, 32'd0);
        chk("count_end", {23'h0, ld_count}, exp_n);
        tick();
        chk("done_single", {31'h0, ld_done}, 32'd0);
        chk("count_hold", {23'h0, ld_count}, exp_n);
    endtask

    initial begin
        reset = 1'b0;
        i_addr = '0; d_addr = '0; d_dataout = '0; d_we = 1'b0;
        ld_start = 1'b0; ld_sel = 1'b0; ld_valid = 1'b0; ld_data = '0; ld_last = 1'b0;
        repeat (3) tick();
        chk("rst_ready", {31'h0, ld_ready}, 32'd0);
        chk("rst_busy", {31'h0, ld_busy}, 32'd0);
        chk("rst_done", {31'h0, ld_done}, 32'd0);
        chk("rst_count", {23'h0, ld_count}, 32'd0);
        reset = 1'b1;
        tick();

        // Small program into imem, terminated by ld_last.
        words = '{16'h8101, 16'h8202, 16'h0000, 16'h0800};
        run_load(1'b0, 1'b1, 1'b0);
        readback();

        // Full dmem stream with gaps, ends on wrap.
        words.delete();
        for (int k = 0; k < 256; k++) words.push_back(16'($urandom));
        run_load(1'b1, 1'b0, 1'b1);

        // Host words outside LOAD must not land anywhere.
        ld_valid = 1'b1; ld_data = 16'hDEAD; ld_last = 1'b1;
        repeat (3) tick();
        chk("idle_valid_busy", {31'h0, ld_busy}, 32'd0);
        chk("idle_valid_count", {23'h0, ld_count}, 32'd256);
        ld_valid = 1'b0; ld_last = 1'b0;
        readback();

        // CPU store: old word in the write cycle, new word afterwards.
        d_addr = 8'h10; d_dataout = 16'hBEEF; d_we = 1'b1;
        #1;
        chk("rdw_old", {16'h0, d_datain}, {16'h0, dm[8'h10]});
        tick();
        d_we = 1'b0;
        dm[8'h10] = 16'hBEEF;
        #1;
        chk("rdw_new", {16'h0, d_datain}, 32'h0000BEEF);

        // Random CPU traffic against the model.
        for (int k = 0; k < 60; k++) begin
            d_addr    = 8'($urandom);
            i_addr    = 8'($urandom);
            d_dataout = 16'($urandom);
            d_we      = 1'($urandom);
            #1;
            if (dm_v[d_addr]) chk("cpu_dread", {16'h0, d_datain}, {16'h0, dm[d_addr]});
            if (im_v[i_addr]) chk("cpu_iread", {16'h0, i_datain}, {16'h0, im[i_addr]});
            tick();
            if (d_we) begin dm[d_addr] = d_dataout; dm_v[d_addr] = 1'b1; end
        end
        d_we = 1'b0;

        // A short imem session with gaps, stray ld_start and blocked stores.
        words.delete();
        for (int k = 0; k < 7; k++) words.push_back(16'($urandom));
        run_load(1'b0, 1'b1, 1'b1);
        readback();

        // Reset after 2 of 5 words.
        ld_start = 1'b1; ld_sel = 1'b0;
        tick();
        ld_start = 1'b0;
        for (int k = 0; k < 2; k++) begin
            ld_valid = 1'b1; ld_data = 16'h1110 + 16'(k);
            tick();
            im[k] = 16'h1110 + 16'(k);
        end
        ld_valid = 1'b1; ld_data = 16'h5A5A;
        reset = 1'b0;
        #1;
        chk("midrst_busy", {31'h0, ld_busy}, 32'd0);
        chk("midrst_ready", {31'h0, ld_ready}, 32'd0);
        chk("midrst_done", {31'h0, ld_done}, 32'd0);
        chk("midrst_count", {23'h0, ld_count}, 32'd0);
        tick();
        ld_valid = 1'b0;
        reset = 1'b1;
        tick();
        readback();

        // New session restarts at address 0.
        words = '{16'h7001, 16'h7002};
        run_load(1'b0, 1'b1, 1'b0);
        readback();

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/cpu_mem.md
# cpu_mem

Memory responder for the pipelined 16-bit CPU. It holds a 256×16 instruction memory and a 256×16 data memory and answers the CPU's i_addr/d_addr/d_we requests with the read timing the pipeline expects. It also contains a host program-loader FSM with a valid/ready handshake, which fills either memory while the CPU is idle. It sits beside the CPU in the top level and connects port-for-port to the CPU memory signals.

## Interface
- ADDR_W, 8, address width for both memories
- DATA_W, 16, word width
- DEPTH, 256, words per memory (equals 2**ADDR_W)
- clock  in  1  single system clock, all writes on rising edge
- reset  in  1  asynchronous, active-low; clears loader state only, not memory contents
- i_addr  in  ADDR_W  instruction fetch address (CPU pc)
- i_datain  out  DATA_W  instruction word to CPU
- d_addr  in  ADDR_W  data address (CPU reg_C[7:0])
- d_dataout  in  DATA_W  CPU store data
- d_we  in  1  CPU store strobe
- d_datain  out  DATA_W  load data to CPU
- ld_start  in  1  begin a load session, sampled in IDLE only
- ld_sel  in  1  target memory, 0 = instruction, 1 = data; latched at ld_start
- ld_valid  in  1  host word valid
- ld_data  in  DATA_W  host word
- ld_last  in  1  marks the final word, qualified by ld_valid
- ld_ready  out  1  loader accepts a word this cycle
- ld_busy  out  1  high in LOAD; the top level ties the CPU enable low while this is high
- ld_done  out  1  one-cycle pulse at end of session
- ld_count  out  ADDR_W+1  words written in the current or last session

## Operation
- Reads are combinational: i_datain = imem[i_addr] and d_datain = dmem[d_addr]. The CPU samples both on the same edge it presents the address.
- CPU write: on a rising edge with d_we=1 and state≠LOAD, dmem[d_addr] <= d_dataout.
- FSM states IDLE, LOAD, DONE:
  - IDLE: when ld_start=1, go to LOAD, latch ld_sel, clear the pointer and ld_count to 0.
  - LOAD: ld_ready=1. A word is accepted when ld_valid & ld_ready. Each accepted word is written to the selected memory at the pointer, then the pointer and ld_count increment.
  - LOAD exit: leave for DONE when an accepted word has ld_last=1, or when the pointer was 255 (wrap). A wrap therefore ends the session with ld_count=256; the pointer never wraps into address 0.
  - DONE: ld_done=1 for exactly one cycle, then IDLE. ld_count holds until the next ld_start.
- While in LOAD:
  - d_we is ignored; the loader has sole write access.
  - i_datain is forced to 16'h0000, so the CPU sees zero (NOP) words.
  - d_datain still reads normally.
- ld_start outside IDLE is ignored. ld_valid outside LOAD is ignored and no write occurs.
- Reset mid-session: the FSM returns to IDLE immediately. Words already written stay in memory. ld_count, ld_ready, ld_busy and ld_done go to 0.

## Timing
- Reset values: ld_ready=0, ld_busy=0, ld_done=0, ld_count=0. i_datain and d_datain reflect the memory at the current address, whose content is undefined after power-up.
- Read latency is 0 cycles (combinational). Write latency is 1 edge.
- Read-during-write to the same address returns the old word in that cycle and the new word from the next cycle.
- ld_ready rises the cycle after ld_start is sampled and drops the cycle after the last accepted word.
- ld_done asserts the cycle after the last accept. ld_busy spans exactly the LOAD state.
- Throughput in LOAD is one word per cycle.

## Structure
- The shared package (config.v style defines) holds the FSM state encodings (LD_IDLE/LD_LOAD/LD_DONE), MEM_DEPTH, and the zero16/zero8 constants already in use.
- One sub-module, mem_bank: a DEPTH×DATA_W array with one combinational read port and one synchronous write port. It is instantiated twice, as imem and dmem.
- Write muxing (loader vs CPU) and the FSM live in cpu_mem.

## Test plan
- Reset then load 4 words (ld_sel=0, 16'h8101, 16'h8202, 16'h0000, 16'h0800 with ld_last on the 4th) -> ld_count=4, ld_done single pulse, imem[0..3] read back via i_addr.
- Backpressure-free streaming: 256 data words with no ld_last -> session ends on wrap, ld_count=256, dmem[255]=last word, dmem[0] not overwritten twice.
- CPU store d_addr=8'h10, d_dataout=16'hBEEF, d_we=1 -> d_datain shows old value that cycle and 16'hBEEF the next.
- d_we=1 during LOAD -> dmem unchanged at d_addr; i_datain=16'h0000 throughout LOAD.
- Reset asserted after 2 of 5 words -> ld_busy/ld_ready drop immediately, words 0-1 retained, word 2 absent; a new ld_start restarts at address 0.
- ld_start pulsed in LOAD and ld_valid pulsed in IDLE -> no state change, no memory write.
